// File: rtl/pmem_arbiter.sv
// Two-requester arbiter that shares one physical-memory port between the I- and D-caches.
// Define PMEM_ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise the D side always wins.
module pmem_arbiter #(
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_pmem_read,
   input  logic [31:0]           i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [31:0]           d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [31:0]           pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
   typedef enum logic {GRANT_I, GRANT_D} grant_t;

   state_t state, state_next;
   grant_t last_grant, last_grant_next;
   logic   i_pending, d_pending, d_wins;

   assign i_pending = i_pmem_read;
   assign d_pending = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
   assign d_wins = (last_grant == GRANT_I);
`else
   // D always wins; last_grant is still tracked so both builds share the same state.
   assign d_wins = (last_grant == GRANT_I) || (last_grant == GRANT_D);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= GRANT_I;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
      end
   end

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      case (state)
         IDLE: begin
            if (i_pending && d_pending) begin
               if (d_wins) begin
                  state_next      = D_BUSY;
                  last_grant_next = GRANT_D;
               end else begin
                  state_next      = I_BUSY;
                  last_grant_next = GRANT_I;
               end
            end else if (i_pending) begin
               state_next      = I_BUSY;
               last_grant_next = GRANT_I;
            end else if (d_pending) begin
               state_next      = D_BUSY;
               last_grant_next = GRANT_D;
            end
         end
         I_BUSY:  if (pmem_resp) state_next = IDLE;
         D_BUSY:  if (pmem_resp) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory-side strobes come straight from the state so reset clears them without waiting for a clock.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
      case (state)
         I_BUSY: begin
            pmem_read    = 1'b1;
            pmem_address = i_pmem_address;
            i_pmem_resp  = pmem_resp;
         end
         D_BUSY: begin
            pmem_read    = d_pmem_read & ~d_pmem_write;
            pmem_write   = d_pmem_write;
            pmem_address = d_pmem_address;
            pmem_wdata   = d_pmem_wdata;
            d_pmem_resp  = pmem_resp;
         end
         default: ;
      endcase
   end

   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: expected grants are queued as requests are driven
// and retired as the arbiter presents them on the memory port.
module tb_pmem_arbiter;

   localparam int LW = 256;

   logic          clk;
   logic          rst_n;
   logic          i_pmem_read;
   logic [31:0]   i_pmem_address;
   logic [LW-1:0] i_pmem_rdata;
   logic          i_pmem_resp;
   logic          d_pmem_read;
   logic          d_pmem_write;
   logic [31:0]   d_pmem_address;
   logic [LW-1:0] d_pmem_wdata;
   logic [LW-1:0] d_pmem_rdata;
   logic          d_pmem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [31:0]   pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   typedef struct {
      string         tag;
      bit            is_d;
      bit            is_write;
      logic [31:0]   addr;
      logic [LW-1:0] wdata;
      logic [LW-1:0] rdata;
   } txn_t;

   txn_t scoreboard[$];
   int   checkCount;
   int   errorCount;

   pmem_arbiter #(.LINE_WIDTH(LW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [LW-1:0] observed, input logic [LW-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit i_rd, input bit d_rd, input bit d_wr,
                                input logic [31:0] i_addr, input logic [31:0] d_addr,
                                input logic [LW-1:0] wdata);
      @(posedge clk);
      #1;
      i_pmem_read    = i_rd;
      i_pmem_address = i_addr;
      d_pmem_read    = d_rd;
      d_pmem_write   = d_wr;
      d_pmem_address = d_addr;
      d_pmem_wdata   = wdata;
   endtask

   task automatic pushExpected(input string tag, input bit is_d, input bit is_write,
                               input logic [31:0] addr, input logic [LW-1:0] wdata);
      txn_t t;
      t.tag      = tag;
      t.is_d     = is_d;
      t.is_write = is_write;
      t.addr     = addr;
      t.wdata    = wdata;
      t.rdata    = {8{$urandom()}};
      scoreboard.push_back(t);
   endtask

   task automatic releaseRequests();
      i_pmem_read  = 1'b0;
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
   endtask

   // Acts as the physical memory: waits for a grant, retires the oldest expected transaction, then responds.
   task automatic serveMemory(input int latency, input bit dropMid, input bit releaseAfter, input bit checkPrompt);
      txn_t exp;
      int   waited;
      waited = 0;
      @(negedge clk);
      while (!(pmem_read || pmem_write) && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (scoreboard.size() == 0) begin
         checkOutput("scoreboard_empty", 1'b1, 1'b0);
         return;
      end
      exp = scoreboard.pop_front();
      if (!(pmem_read || pmem_write)) begin
         checkOutput({exp.tag, "_grant_timeout"}, 1'b0, 1'b1);
         releaseRequests();
         return;
      end
      if (checkPrompt) checkOutput({exp.tag, "_grant_cycle"}, LW'(waited), LW'(1));
      checkOutput({exp.tag, "_pmem_read"}, pmem_read, !exp.is_write);
      checkOutput({exp.tag, "_pmem_write"}, pmem_write, exp.is_write);
      checkOutput({exp.tag, "_pmem_address"}, pmem_address, exp.addr);
      if (exp.is_write) checkOutput({exp.tag, "_pmem_wdata"}, pmem_wdata, exp.wdata);
      if (dropMid) releaseRequests();
      repeat (latency) @(negedge clk);
      checkOutput({exp.tag, "_strobe_held"}, {pmem_read, pmem_write}, {!exp.is_write, exp.is_write});
      pmem_rdata = exp.rdata;
      pmem_resp  = 1'b1;
      #1;
      checkOutput({exp.tag, "_i_resp"}, i_pmem_resp, !exp.is_d);
      checkOutput({exp.tag, "_d_resp"}, d_pmem_resp, exp.is_d);
      checkOutput({exp.tag, "_rdata"}, exp.is_d ? d_pmem_rdata : i_pmem_rdata, exp.rdata);
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (releaseAfter) releaseRequests();
      @(negedge clk);
      checkOutput({exp.tag, "_idle_strobes"}, {pmem_read, pmem_write}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [LW-1:0] ones;
      ones         = '1;
      checkCount   = 0;
      errorCount   = 0;
      rst_n        = 1'b0;
      pmem_resp    = 1'b0;
      pmem_rdata   = '0;
      d_pmem_wdata = '0;
      i_pmem_address = '0;
      d_pmem_address = '0;
      releaseRequests();

      #3;
      checkOutput("reset_pmem_read", pmem_read, 1'b0);
      checkOutput("reset_pmem_write", pmem_write, 1'b0);
      checkOutput("reset_i_resp", i_pmem_resp, 1'b0);
      checkOutput("reset_d_resp", d_pmem_resp, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single I read: grant one cycle after the request, response three cycles later.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, '0);
      pushExpected("i_read", 1'b0, 1'b0, 32'h0000_1000, '0);
      serveMemory(3, 1'b0, 1'b1, 1'b1);

      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0040, ones);
      pushExpected("d_write", 1'b1, 1'b1, 32'h8000_0040, ones);
      serveMemory(2, 1'b0, 1'b1, 1'b1);

      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_2220, '0);
      pushExpected("d_read", 1'b1, 1'b0, 32'h0000_2220, '0);
      serveMemory(1, 1'b0, 1'b1, 1'b1);

      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_3340, {8{32'hA5A5_5A5A}});
      pushExpected("d_rw_both", 1'b1, 1'b1, 32'h0000_3340, {8{32'hA5A5_5A5A}});
      serveMemory(2, 1'b0, 1'b1, 1'b1);

      // I requester withdraws after the grant; the transaction must still run to completion.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_4400, 32'h0, '0);
      pushExpected("i_drop_mid", 1'b0, 1'b0, 32'h0000_4400, '0);
      serveMemory(4, 1'b1, 1'b1, 1'b1);

      // Reset asserted two cycles into a D write.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h1234_0000, ones);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_mid_granted", pmem_write, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_pmem_write", pmem_write, 1'b0);
      checkOutput("rst_mid_pmem_read", pmem_read, 1'b0);
      checkOutput("rst_mid_d_resp", d_pmem_resp, 1'b0);
      releaseRequests();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pmem_resp = 1'b1;
      #1;
      checkOutput("rst_late_resp_d", d_pmem_resp, 1'b0);
      checkOutput("rst_late_resp_i", i_pmem_resp, 1'b0);
      @(negedge clk);
      checkOutput("rst_late_strobes", {pmem_read, pmem_write}, 2'b00);
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;

      // Stray memory response while idle.
      @(negedge clk);
      pmem_resp = 1'b1;
      #1;
      checkOutput("idle_resp_i", i_pmem_resp, 1'b0);
      checkOutput("idle_resp_d", d_pmem_resp, 1'b0);
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      @(negedge clk);
      checkOutput("idle_resp_strobes", {pmem_read, pmem_write}, 2'b00);

      // Continuous contention; last_grant was returned to I by the reset above.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, '0);
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      pushExpected("contend0_d", 1'b1, 1'b0, 32'h0000_0200, '0);
      pushExpected("contend1_i", 1'b0, 1'b0, 32'h0000_0100, '0);
      pushExpected("contend2_d", 1'b1, 1'b0, 32'h0000_0200, '0);
      pushExpected("contend3_i", 1'b0, 1'b0, 32'h0000_0100, '0);
      serveMemory(2, 1'b0, 1'b0, 1'b1);
      serveMemory(1, 1'b0, 1'b0, 1'b0);
      serveMemory(3, 1'b0, 1'b0, 1'b0);
      serveMemory(1, 1'b0, 1'b1, 1'b0);
`else
      pushExpected("contend0_d", 1'b1, 1'b0, 32'h0000_0200, '0);
      pushExpected("contend1_d", 1'b1, 1'b0, 32'h0000_0200, '0);
      pushExpected("contend2_d", 1'b1, 1'b0, 32'h0000_0200, '0);
      serveMemory(2, 1'b0, 1'b0, 1'b1);
      serveMemory(1, 1'b0, 1'b0, 1'b0);
      serveMemory(3, 1'b0, 1'b1, 1'b0);
`endif

      checkOutput("scoreboard_drained", LW'(scoreboard.size()), LW'(0));
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001: Parameter LINE_WIDTH, default 256, width in bits of one cache line and of every data bus.
REQ-002: Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_pmem_read  input  1  instruction-side line read request.
- i_pmem_address  input  32  instruction-side line address.
- i_pmem_rdata  output  LINE_WIDTH  instruction-side read data.
- i_pmem_resp  output  1  instruction-side completion pulse.
- d_pmem_read  input  1  data-side line read request.
- d_pmem_write  input  1  data-side line write request.
- d_pmem_address  input  32  data-side line address.
- d_pmem_wdata  input  LINE_WIDTH  data-side write data.
- d_pmem_rdata  output  LINE_WIDTH  data-side read data.
- d_pmem_resp  output  1  data-side completion pulse.
- pmem_read  output  1  physical-memory read strobe.
- pmem_write  output  1  physical-memory write strobe.
- pmem_address  output  32  physical-memory address.
- pmem_wdata  output  LINE_WIDTH  physical-memory write data.
- pmem_rdata  input  LINE_WIDTH  physical-memory read data.
- pmem_resp  input  1  physical-memory completion pulse.

Function
REQ-003: FSM states: IDLE, I_BUSY, D_BUSY; exactly one state active.
REQ-004: IDLE: no request -> stay IDLE; only I pending -> I_BUSY; only D pending (read or write) -> D_BUSY; both pending -> winner per REQ-012.
REQ-005: Grant is registered: a request first seen in IDLE at cycle N drives pmem_read/pmem_write from cycle N+1.
REQ-006: I_BUSY: pmem_read=1, pmem_write=0, pmem_address=i_pmem_address; D_BUSY: pmem_read=d_pmem_read AND NOT d_pmem_write, pmem_write=d_pmem_write, pmem_address=d_pmem_address, pmem_wdata=d_pmem_wdata.
REQ-007: d_pmem_read and d_pmem_write both high is treated as a write.
REQ-008: In a BUSY state, pmem_resp=1 drives the granted side's resp to 1 in the same cycle, with pmem_rdata passed through to its rdata; the next state is IDLE.
REQ-009: The non-granted side's resp is 0 at all times; both rdata outputs carry pmem_rdata unconditionally.
REQ-010: IDLE lasts at least one cycle between transactions; pmem_read and pmem_write are 0 in IDLE.
REQ-011: pmem_resp in IDLE is ignored; it causes no resp output and no state change.
REQ-012: A flop last_grant (I or D) updates on every IDLE->BUSY transition; contention winner per REQ-015.
REQ-013: A requester deasserting mid-transaction does not abort it; the arbiter stays BUSY until pmem_resp.

Reset
REQ-014: While rst_n=0 (asynchronously, including mid-transaction): state=IDLE, last_grant=I, all pmem strobes and both resp outputs 0; an in-flight memory response arriving after release is ignored per REQ-011.

Configuration
REQ-015: Macro PMEM_ARB_ROUND_ROBIN_EN: defined -> on contention, grant the side not equal to last_grant (first contention after reset goes to D); undefined -> on contention D always wins, and last_grant is still maintained but unused.

Verification
REQ-016: Scenario: i_pmem_read=1 alone at cycle 0 with address 0x0000_1000 -> pmem_read=1 and pmem_address=0x0000_1000 at cycle 1; pmem_resp at cycle 4 -> i_pmem_resp=1 at cycle 4; IDLE at cycle 5.
REQ-017: Scenario: d_pmem_write=1 alone with address 0x8000_0040 and wdata all-ones -> pmem_write=1 with those values next cycle; d_pmem_resp pulses with pmem_resp; i_pmem_resp stays 0.
REQ-018: Scenario: I and D requesting together from reset, held continuously -> grants D, I, D, I under PMEM_ARB_ROUND_ROBIN_EN, and D, D, D without it (I starved).
REQ-019: Scenario: rst_n dropped two cycles into a D_BUSY transaction -> pmem_write=0 immediately (before the next clk edge); a pmem_resp after release yields no d_pmem_resp.
REQ-020: Scenario: pmem_resp=1 while IDLE with no requests -> both resp outputs 0 and state stays IDLE.
REQ-021: Scenario: d_pmem_read and d_pmem_write both 1 -> pmem_write=1 and pmem_read=0 in D_BUSY.
